rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the RV32I DataPath over a single shared, handshaked memory port. Instruction fetch and data access share that port. The block decodes op/f3/f7 from the DataPath into steering controls (branch, jump, resultSrc, inmSrc, aluSrc, aluControl). It gates all architectural-state strobes (instruction latch, PC update, register write, memory write) so each instruction commits exactly once. It sits between the DataPath, the memory port and the top level.

Parameters:
- TIMEOUT_CYCLES, 16: memory-wait cycle limit before a bus-error trap (used only with CTRL_TIMEOUT_EN).
- TO_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  opcode from DataPath.
- f3  in  3  funct3 from DataPath.
- f7  in  1  funct7[5] from DataPath.
- zero  in  1  ALU zero flag; informational, since branch resolution is done in the DataPath.
- mem_ready  in  1  memory access complete this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write (sw data phase).
- instr_en  out  1  load fetched word into DataPath instr register.
- pc_en  out  1  PC update enable.
- regWrite  out  1  register-file write strobe.
- branch, jump  out  1 each  DataPath PC-select controls.
- resultSrc  out  2  00 aluRes, 01 readData, 10 pc+4.
- inmSrc  out  2  00 I, 01 S, 10 B, 11 J.
- aluSrc  out  1  0 = rs2, 1 = immediate.
- aluControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal  out  1  sticky trap flag.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, TRAP. Asynchronous rst forces IDLE. In IDLE every output is 0. IDLE always goes to FETCH on the next edge.
- FETCH: mem_req=1, mem_we=0.
  - On mem_ready: instr_en=1 in the same cycle, next state DECODE.
  - Otherwise hold FETCH.
- DECODE: one cycle with no strobes. Legal ops are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111.
  - Legal op: go to EXEC.
  - Any other op: go to TRAP.
- EXEC:
  - R, I-ALU, beq, jal: pc_en=1. regWrite=1 except for beq. Next state FETCH.
  - lw, sw: no strobes, next state MEM.
- MEM: mem_req=1; mem_we=1 only for sw. Hold until mem_ready. On mem_ready:
  - lw: regWrite=1, resultSrc=01, pc_en=1.
  - sw: pc_en=1.
  - Next state FETCH.
- TRAP: illegal=1, all strobes 0, no memory request. Stays in TRAP until rst.
- Steering decode is combinational from op/f3/f7 and valid in DECODE, EXEC and MEM. Its value in other states is don't-care.
  - R: aluSrc=0, resultSrc=00. aluControl: f3=000 gives add, or sub when f7=1; 111 and; 110 or; 010 slt.
  - I-ALU: same decode as R but aluSrc=1, inmSrc=00, and f7 ignored (always add for f3=000).
  - lw: aluSrc=1, inmSrc=00, aluControl=add, resultSrc=01.
  - sw: aluSrc=1, inmSrc=01, aluControl=add.
  - beq: branch=1, aluSrc=0, inmSrc=10, aluControl=sub.
  - jal: jump=1, inmSrc=11, resultSrc=10.
- Strobes regWrite, pc_en, instr_en and mem_we are single-cycle. Each is asserted at most once per instruction.
- Latency, with mem_ready=1 on first request:
  - ALU, branch and jump instructions: 4 cycles (FETCH, DECODE, EXEC, back to FETCH).
  - Loads and stores: 5 cycles.
- mem_ready is ignored outside FETCH and MEM.
- rst asserted mid-access drops mem_req asynchronously; no partial commit occurs.
- mem_req stays high continuously while waiting.

Optional Feature:
- CTRL_TIMEOUT_EN defined: a TO_W-bit counter clears on entry to FETCH or MEM and increments each cycle mem_ready=0. When it reaches TIMEOUT_CYCLES, the FSM goes to TRAP with illegal=1, mem_req=0, and no commit.
- Undefined: no counter is present, and the FSM waits on mem_ready indefinitely.

Test Plan:
- Reset and idle: rst=1 for 3 cycles, then release → all outputs 0 during reset and in IDLE, then mem_req=1 in FETCH on the next cycle.
- ALU instruction: add (op=0110011, f3=000, f7=0) with mem_ready=1 → instr_en on cycle 1, regWrite=1, pc_en=1, aluControl=000 in EXEC, next FETCH 3 cycles after the first. Repeat with f7=1 → aluControl=001.
- Load with wait: lw with mem_ready low for 3 MEM cycles → mem_req held for 4 cycles, mem_we=0, then a single cycle with regWrite=1 and resultSrc=01. sw → mem_we=1 in MEM and regWrite never asserted.
- Branch and jump: beq → branch=1, inmSrc=10, pc_en=1, regWrite=0. jal → jump=1, resultSrc=10, regWrite=1.
- Illegal opcode: op=1111111 → TRAP after DECODE with illegal=1 and no further mem_req. Assert rst mid-MEM → mem_req drops immediately, no regWrite, return to IDLE.
- With CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16: mem_ready held 0 in FETCH → illegal=1 after exactly 16 wait cycles.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multi-cycle RV32I control FSM sequencing fetch/decode/exec/mem over one shared memory port.
// Define CTRL_TIMEOUT_EN to trap when a memory wait lasts TIMEOUT_CYCLES cycles.
module rv_multicycle_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TO_W = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] f3,
   input  logic       f7,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       instr_en,
   output logic       pc_en,
   output logic       regWrite,
   output logic       branch,
   output logic       jump,
   output logic [1:0] resultSrc,
   output logic [1:0] inmSrc,
   output logic       aluSrc,
   output logic [2:0] aluControl,
   output logic       illegal
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, TRAP} ctrlState;
   ctrlState state, next;
   logic isR, isI, isLw, isSw, isBeq, isJal, isMemOp, legal, steerOn, memWait, timeout;
   logic [2:0] aluOp;
   logic unusedZero;
   assign unusedZero = zero;
   assign isR = op == 7'b0110011;
   assign isI = op == 7'b0010011;
   assign isLw = op == 7'b0000011;
   assign isSw = op == 7'b0100011;
   assign isBeq = op == 7'b1100011;
   assign isJal = op == 7'b1101111;
   assign isMemOp = isLw || isSw;
   assign legal = isR || isI || isMemOp || isBeq || isJal;
   assign memWait = (state == FETCH || state == MEM) && !mem_ready;
`ifdef CTRL_TIMEOUT_EN
   logic [TO_W-1:0] toCnt;
   // Any cycle that is not a stalled FETCH/MEM cycle restarts the count, so it clears on entry.
   always_ff @(posedge clk or posedge rst)
      if (rst) toCnt <= '0;
      else toCnt <= memWait ? toCnt + TO_W'(1) : '0;
   assign timeout = memWait && toCnt == TO_W'(TIMEOUT_CYCLES - 1);
`else
   logic [TO_W-1:0] unusedTo;
   assign unusedTo = TO_W'(TIMEOUT_CYCLES);
   assign timeout = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      mem_req = 1'b0;
      mem_we = 1'b0;
      instr_en = 1'b0;
      pc_en = 1'b0;
      regWrite = 1'b0;
      case (state)
         IDLE: next = FETCH;
         FETCH: begin
            mem_req = 1'b1;
            instr_en = mem_ready;
            next = mem_ready ? DECODE : FETCH;
         end
         DECODE: next = legal ? EXEC : TRAP;
         EXEC: begin
            pc_en = !isMemOp;
            regWrite = isR || isI || isJal;
            next = isMemOp ? MEM : FETCH;
         end
         MEM: begin
            mem_req = 1'b1;
            mem_we = isSw;
            regWrite = mem_ready && isLw;
            pc_en = mem_ready;
            next = mem_ready ? FETCH : MEM;
         end
         default: next = TRAP;
      endcase
      if (timeout) next = TRAP;
   end
   assign illegal = state == TRAP;
   // Steering is forced to zero outside DECODE/EXEC/MEM so IDLE presents all-zero outputs.
   assign steerOn = state == DECODE || state == EXEC || state == MEM;
   assign aluOp = f3 == 3'b000 ? {2'b00, isR && f7} :
                  f3 == 3'b111 ? 3'b010 :
                  f3 == 3'b110 ? 3'b011 :
                  f3 == 3'b010 ? 3'b101 : 3'b000;
   assign branch = steerOn && isBeq;
   assign jump = steerOn && isJal;
   assign aluSrc = steerOn && (isI || isMemOp);
   assign resultSrc = !steerOn ? 2'b00 : isLw ? 2'b01 : isJal ? 2'b10 : 2'b00;
   assign inmSrc = !steerOn ? 2'b00 : isSw ? 2'b01 : isBeq ? 2'b10 : isJal ? 2'b11 : 2'b00;
   assign aluControl = !steerOn ? 3'b000 : isBeq ? 3'b001 : (isR || isI) ? aluOp : 3'b000;
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: table-driven cycle-by-cycle check of rv_multicycle_ctrl plus reset corner sequences.
module tb_rv_multicycle_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   logic [6:0] op = '0;
   logic [2:0] f3 = '0;
   logic f7 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
   logic mem_req, mem_we, instr_en, pc_en, regWrite, branch, jump, aluSrc, illegal;
   logic [1:0] resultSrc, inmSrc;
   logic [2:0] aluControl;
   int compared = 0, mismatched = 0;

   rv_multicycle_ctrl dut (
      .clk(clk), .rst(rst), .op(op), .f3(f3), .f7(f7), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .instr_en(instr_en), .pc_en(pc_en), .regWrite(regWrite),
      .branch(branch), .jump(jump), .resultSrc(resultSrc), .inmSrc(inmSrc), .aluSrc(aluSrc),
      .aluControl(aluControl), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // strobes {mem_req,mem_we,instr_en,pc_en,regWrite,illegal}; steer {branch,jump,resultSrc,inmSrc,aluSrc,aluControl}
   localparam logic [5:0] S0 = 6'b000000, SF = 6'b101000, SW = 6'b100000, SX = 6'b000110,
                          SP = 6'b000100, SL = 6'b100110, SS = 6'b110100, ST = 6'b000001;
   localparam logic [6:0] OR_ = 7'b0110011, OI = 7'b0010011, OL = 7'b0000011, OS = 7'b0100011,
                          OB = 7'b1100011, OJ = 7'b1101111, OX = 7'b1111111;
   localparam logic [9:0] MALL = 10'h3ff, MNONE = 10'h000, MR = 10'b11_11_00_1_111,
                          MSB = 10'b11_00_11_1_111, MJ = 10'b11_11_11_0_000;

   typedef struct {
      string name;
      logic r;
      logic [6:0] o;
      logic [2:0] f;
      logic s;
      logic y;
      logic [5:0] es;
      logic [9:0] ev;
      logic [9:0] m;
   } vecT;
   vecT vt[$];

   function automatic void add(string n, logic r, logic [6:0] o, logic [2:0] f, logic s, logic y,
                               logic [5:0] es, logic [9:0] ev, logic [9:0] m);
      vt.push_back('{n, r, o, f, s, y, es, ev, m});
   endfunction

   function automatic void instr3(string n, logic [6:0] o, logic [2:0] f, logic s, logic [5:0] es,
                                  logic [9:0] ev, logic [9:0] m);
      add({n, "_fetch"}, 0, o, f, s, 1, SF, 0, MNONE);
      add({n, "_decode"}, 0, o, f, s, 1, S0, ev, m);
      add({n, "_exec"}, 0, o, f, s, 1, es, ev, m);
   endfunction

   task automatic check(string n, logic [5:0] es, logic [9:0] ev, logic [9:0] m);
      logic [5:0] as;
      logic [9:0] av;
      as = {mem_req, mem_we, instr_en, pc_en, regWrite, illegal};
      av = {branch, jump, resultSrc, inmSrc, aluSrc, aluControl};
      compared++;
      if (as !== es || (av & m) !== (ev & m)) begin
         mismatched++;
         $display("FAIL %s: strobes=%b steer=%b, required strobes=%b steer=%b (mask %b)", n, as, av, es, ev, m);
      end
   endtask

   initial begin
      add("add_fetch_wait0", 0, OR_, 3'b000, 0, 0, SW, 0, MNONE);
      add("add_fetch_wait1", 0, OR_, 3'b000, 0, 0, SW, 0, MNONE);
      instr3("add", OR_, 3'b000, 0, SX, 10'b0_0_00_00_0_000, MR);
      instr3("sub", OR_, 3'b000, 1, SX, 10'b0_0_00_00_0_001, MR);
      instr3("and", OR_, 3'b111, 0, SX, 10'b0_0_00_00_0_010, MR);
      instr3("slt", OR_, 3'b010, 0, SX, 10'b0_0_00_00_0_101, MR);
      instr3("ori", OI, 3'b110, 0, SX, 10'b0_0_00_00_1_011, MALL);
      instr3("addi_f7", OI, 3'b000, 1, SX, 10'b0_0_00_00_1_000, MALL);
      instr3("lw", OL, 3'b010, 0, S0, 10'b0_0_01_00_1_000, MALL);
      add("lw_mem_wait0", 0, OL, 3'b010, 0, 0, SW, 10'b0_0_01_00_1_000, MALL);
      add("lw_mem_wait1", 0, OL, 3'b010, 0, 0, SW, 10'b0_0_01_00_1_000, MALL);
      add("lw_mem_wait2", 0, OL, 3'b010, 0, 0, SW, 10'b0_0_01_00_1_000, MALL);
      add("lw_mem_done", 0, OL, 3'b010, 0, 1, SL, 10'b0_0_01_00_1_000, MALL);
      instr3("sw", OS, 3'b010, 0, S0, 10'b0_0_00_01_1_000, MSB);
      add("sw_mem_done", 0, OS, 3'b010, 0, 1, SS, 10'b0_0_00_01_1_000, MSB);
      instr3("beq", OB, 3'b000, 0, SP, 10'b1_0_00_10_0_001, MSB);
      instr3("jal", OJ, 3'b000, 0, SX, 10'b0_1_10_11_0_000, MJ);
      add("ill_fetch", 0, OX, 3'b000, 0, 1, SF, 0, MNONE);
      add("ill_decode", 0, OX, 3'b000, 0, 1, S0, 0, MNONE);
      for (int i = 0; i < 3; i++) add("trap_hold", 0, OX, 3'b000, 0, 1, ST, 0, MNONE);
      add("trap_rst", 1, OX, 3'b000, 0, 1, S0, 0, MALL);
      add("post_rst_idle", 0, OR_, 3'b000, 0, 1, S0, 0, MALL);
      instr3("lw2", OL, 3'b010, 0, S0, 10'b0_0_01_00_1_000, MALL);
      add("lw2_mem_wait", 0, OL, 3'b010, 0, 0, SW, 10'b0_0_01_00_1_000, MALL);

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 check("reset", S0, 0, MALL);
      end
      rst = 1'b0;
      #1 check("idle", S0, 0, MALL);

      foreach (vt[i]) begin
         @(negedge clk);
         rst = vt[i].r;
         op = vt[i].o;
         f3 = vt[i].f;
         f7 = vt[i].s;
         mem_ready = vt[i].y;
         #1 check(vt[i].name, vt[i].es, vt[i].ev, vt[i].m);
      end

      // Still stalled in MEM for lw2: rst mid-access must drop mem_req with no commit.
      @(negedge clk);
      mem_ready = 1'b0;
      #1 check("mem_before_rst", SW, 10'b0_0_01_00_1_000, MALL);
      #1 rst = 1'b1;
      mem_ready = 1'b1;
      #1 check("mem_rst_async", S0, 0, MALL);
      @(posedge clk);
      #1 check("mem_rst_hold", S0, 0, MALL);
      @(negedge clk);
      rst = 1'b0;
      mem_ready = 1'b0;
      #1 check("mem_rst_idle", S0, 0, MALL);
      @(negedge clk);
      #1 check("mem_rst_refetch", SW, 0, MNONE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
